adder_functional_unit: RTL and testbench
========================================

Name: adder_functional_unit

Overview:
- Adder functional unit for the Tomasulo adder reservation station.
- Takes an issued 16-bit instruction and reads its two source operands from architectural registers R1..R7 through an internal 7:1 operand multiplexer.
- Computes ADD or SUB over a fixed multi-cycle latency.
- Reports the result with a one-cycle done pulse plus the destination register index, so the station can clear dependencies.

Parameters:
- LATENCY, 2, cycles from instruction acceptance to the done pulse; legal range 1..15.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Resetn  input  1  synchronous reset, active-low.
- instOut  input  16  issued instruction. [15:13] opcode, [12:10] destination, [9:7] source X, [6:4] source Y, [3:0] unused.
- instOutEnable  input  1  issue strobe; instOut is valid this cycle.
- R1..R7  input  16 each  architectural register values.
- busy  output  1  unit is executing; a new issue would be ignored.
- done  output  1  one-cycle result-valid pulse.
- dout  output  16  result; valid while done=1.
- doutAddress  output  3  destination register index of the result; valid while done=1.

Behaviour:
- Operand mux (combinational): select 3'b000 gives 16'h0000; selects 1..7 give R1..R7.
  - X operand is selected by instOut[9:7].
  - Y operand is selected by instOut[6:4].
- Reset: a rising edge with Resetn=0 forces the following, regardless of any operation in progress:
  - busy=0, done=0, dout=0, doutAddress=0, internal counter=0.
  - The in-flight instruction is discarded and no done pulse follows it.
  - Reset has priority over instOutEnable.
- Accept: at a rising edge with Resetn=1, instOutEnable=1 and busy=0, the unit latches:
  - the opcode and the destination instOut[12:10];
  - both mux outputs, sampled at that edge. Later changes to R1..R7 do not affect the result.
  - It then sets busy=1 and loads the counter with LATENCY.
- instOutEnable=1 while busy=1 is ignored. The in-flight result is unchanged and no error is flagged.
- Execute: the counter decrements once per cycle.
  - At the edge where the counter reaches completion, the unit sets done=1, dout=result, doutAddress=latched destination, and busy=0.
  - Timing: acceptance at edge T, then done=1 during the cycle after edge T+LATENCY.
- done is high for exactly one cycle and cleared at the next edge.
- dout and doutAddress hold their values until the next completion or reset.
- Back-to-back: an instOutEnable sampled at the edge that ends the done cycle (busy=0) is accepted. Sustained throughput is one instruction per LATENCY+1 cycles.
- Arithmetic is 16-bit modulo; carry and borrow are discarded.
  - Opcode 3'b000: dout = X + Y.
  - Opcode 3'b001: dout = X - Y.
  - Any other opcode: executed as ADD.
- The destination field is not checked; destination 0 is reported as-is.
- No combinational path from any input to done, dout or doutAddress.

Test Plan:
- Reset: hold Resetn=0 for 2 cycles with instOutEnable=1 -> busy=0, done=0, dout=0, doutAddress=0, and no done pulse follows.
- ADD: R2=16'd5, R3=16'd7; issue opcode 000, dst 4, X=2, Y=3 -> exactly LATENCY cycles later done=1 for one cycle, dout=16'd12, doutAddress=3'd4.
- SUB with wrap: R1=16'd3, R5=16'd10; issue opcode 001, X=1, Y=5 -> dout=16'hFFF9. Also ADD of 16'hFFFF+16'h0001 -> dout=16'h0000.
- Register zero and snapshot: issue ADD with X=0, Y=7 (R7=16'h1234), then change R7 to 16'h0000 during execution -> dout=16'h1234.
- Busy collision: a second issue while busy -> ignored; only the first result is reported. Then issue again during the done cycle -> accepted, with its done exactly LATENCY+1 cycles after the first done.
- Reset mid-operation: assert Resetn=0 for one edge one cycle after issue -> no done pulse, busy=0, and a fresh issue afterward completes normally.

Source files
------------

// File: rtl/adder_functional_unit_if.sv
// Issue/result bundle between the adder reservation station and its functional unit.
// The register file values R1..R7 travel with the issue side.
interface adder_functional_unit_if;
  logic [15:0] instOut;
  logic        instOutEnable;
  logic [15:0] R1;
  logic [15:0] R2;
  logic [15:0] R3;
  logic [15:0] R4;
  logic [15:0] R5;
  logic [15:0] R6;
  logic [15:0] R7;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic [2:0]  doutAddress;

  modport master (
    output instOut, instOutEnable, R1, R2, R3, R4, R5, R6, R7,
    input  busy, done, dout, doutAddress
  );

  modport slave (
    input  instOut, instOutEnable, R1, R2, R3, R4, R5, R6, R7,
    output busy, done, dout, doutAddress
  );
endinterface

// File: rtl/adder_functional_unit.sv
// Multi-cycle ADD/SUB functional unit: snapshots both operands at issue, reports the
// result LATENCY cycles later with a one-cycle done pulse and the destination index.
module adder_functional_unit #(
  parameter int unsigned LATENCY = 2
) (
  input logic                   Clock,
  input logic                   Resetn,
  adder_functional_unit_if.slave bus_io
);

  localparam logic [3:0] LatencyCnt = 4'(LATENCY);
  localparam logic [2:0] OpSub      = 3'b001;

  logic [15:0] regs [8];
  logic [15:0] x_sel, y_sel;
  logic [15:0] result;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] dout_q, dout_d;
  logic [2:0]  addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  logic unused_inst;
  assign unused_inst = ^bus_io.instOut[3:0];

  // Select 0 reads as a hard zero, not a register.
  always_comb begin
    regs[0] = 16'h0000;
    regs[1] = bus_io.R1;
    regs[2] = bus_io.R2;
    regs[3] = bus_io.R3;
    regs[4] = bus_io.R4;
    regs[5] = bus_io.R5;
    regs[6] = bus_io.R6;
    regs[7] = bus_io.R7;
    x_sel   = regs[bus_io.instOut[9:7]];
    y_sel   = regs[bus_io.instOut[6:4]];
  end

  // Unknown opcodes fall through to ADD.
  always_comb begin
    if (op_q == OpSub) begin
      result = x_q - y_q;
    end else begin
      result = x_q + y_q;
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    dout_d = dout_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    dst_d  = dst_q;
    x_d    = x_q;
    y_d    = y_q;
    if (busy_q) begin
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        dout_d = result;
        addr_d = dst_q;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (bus_io.instOutEnable) begin
      busy_d = 1'b1;
      cnt_d  = LatencyCnt;
      op_d   = bus_io.instOut[15:13];
      dst_d  = bus_io.instOut[12:10];
      x_d    = x_sel;
      y_d    = y_sel;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= 16'h0000;
      addr_q <= 3'd0;
      cnt_q  <= 4'd0;
      op_q   <= 3'd0;
      dst_q  <= 3'd0;
      x_q    <= 16'h0000;
      y_q    <= 16'h0000;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      dout_q <= dout_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      dst_q  <= dst_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign bus_io.busy        = busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.dout        = dout_q;
  assign bus_io.doutAddress = addr_q;

endmodule

// File: tb/tb_adder_functional_unit.sv
// Scoreboard bench: the driver predicts each accepted instruction's result and done cycle,
// a monitor compares every cycle's outputs against those predictions.
module tb_adder_functional_unit;

  localparam int LAT = 2;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int          cyc;
    logic [15:0] dout;
    logic [2:0]  addr;
  } exp_t;

  exp_t        sb[$];
  int          acc_edge = -100;
  logic [15:0] r [8];
  logic [15:0] last_dout = 16'h0000;
  logic [2:0]  last_addr = 3'd0;

  adder_functional_unit_if bus ();

  adder_functional_unit #(.LATENCY(LAT)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus_io (bus)
  );

  assign bus.R1 = r[1];
  assign bus.R2 = r[2];
  assign bus.R3 = r[3];
  assign bus.R4 = r[4];
  assign bus.R5 = r[5];
  assign bus.R6 = r[6];
  assign bus.R7 = r[7];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Driven from negedge; accepted at the next rising edge unless the unit is still busy.
  task automatic issue(input logic [2:0] op, input logic [2:0] dst,
                       input logic [2:0] xs, input logic [2:0] ys);
    int          e;
    logic [15:0] xv, yv, res;
    bus.instOut       = {op, dst, xs, ys, 4'($urandom)};
    bus.instOutEnable = 1'b1;
    e = cyc + 1;
    if (e > acc_edge + LAT) begin
      xv  = (xs == 3'd0) ? 16'h0000 : r[xs];
      yv  = (ys == 3'd0) ? 16'h0000 : r[ys];
      res = (op == 3'd1) ? 16'(xv - yv) : 16'(xv + yv);
      sb.push_back('{cyc: e + LAT, dout: res, addr: dst});
      acc_edge = e;
    end
    @(negedge Clock);
    bus.instOutEnable = 1'b0;
  endtask

  task automatic do_reset(input int n);
    Resetn            = 1'b0;
    bus.instOutEnable = 1'b1;
    bus.instOut       = 16'($urandom);
    sb.delete();
    acc_edge = -100;
    repeat (n) @(negedge Clock);
    Resetn            = 1'b1;
    bus.instOutEnable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    exp_t e;
    logic exp_busy;
    forever begin
      @(posedge Clock);
      #1;
      if (!Resetn) begin
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_addr", 32'(bus.doutAddress), 32'd0);
        last_dout = 16'h0000;
        last_addr = 3'd0;
      end else begin
        exp_busy = (acc_edge <= cyc) && (cyc < acc_edge + LAT);
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        if (bus.done === 1'b1) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("dout", 32'(bus.dout), 32'(e.dout));
            chk("dout_addr", 32'(bus.doutAddress), 32'(e.addr));
            last_dout = e.dout;
            last_addr = e.addr;
          end
        end else begin
          if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("missing_done", 32'(bus.done), 32'd1);
            void'(sb.pop_front());
          end
          chk("hold_dout", 32'(bus.dout), 32'(last_dout));
          chk("hold_addr", 32'(bus.doutAddress), 32'(last_addr));
        end
      end
    end
  end

  initial begin
    int e0;
    r[0] = 16'h0000;
    for (int i = 1; i < 8; i++) r[i] = 16'($urandom);
    bus.instOut       = 16'h0000;
    bus.instOutEnable = 1'b0;

    do_reset(2);
    idle(3);

    // ADD
    r[2] = 16'd5; r[3] = 16'd7;
    issue(3'd0, 3'd4, 3'd2, 3'd3);
    idle(LAT + 1);

    // SUB with wrap, then ADD with carry out
    r[1] = 16'd3; r[5] = 16'd10;
    issue(3'd1, 3'd6, 3'd1, 3'd5);
    idle(LAT + 1);
    r[4] = 16'hFFFF; r[6] = 16'h0001;
    issue(3'd0, 3'd0, 3'd4, 3'd6);
    idle(LAT + 1);

    // Register zero and operand snapshot
    r[7] = 16'h1234;
    issue(3'd0, 3'd2, 3'd0, 3'd7);
    r[7] = 16'h0000;
    idle(LAT + 1);

    // Busy collision, then issue during the done cycle
    r[1] = 16'h0100; r[2] = 16'h0020;
    issue(3'd0, 3'd1, 3'd1, 3'd2);
    e0 = acc_edge;
    issue(3'd1, 3'd5, 3'd2, 3'd1);
    while (cyc < e0 + LAT) @(negedge Clock);
    issue(3'd1, 3'd3, 3'd1, 3'd2);
    idle(LAT + 2);

    // Reset one cycle after issue
    issue(3'd0, 3'd7, 3'd1, 3'd2);
    do_reset(1);
    idle(LAT + 2);
    issue(3'd5, 3'd3, 3'd2, 3'd2);
    idle(LAT + 1);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      r[$urandom_range(1, 7)] = 16'($urandom);
      issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      r[$urandom_range(1, 7)] = 16'($urandom);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 2));
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge Clock);
    chk("drain", 32'(sb.size()), 32'd0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
